// File: rtl/angle_rate_meter.sv
// Angle step-rate monitor: times the interval between angle changes and recovers the generator frequency word.
// Define ANGLE_RATE_AVG_EN to report the average of the last four intervals instead of each single interval.
module angle_rate_meter #(
    parameter int                 ANGLE_W  = 12,
    parameter int                 FREQ_W   = 16,
    parameter int                 CNT      = 65536,
    parameter logic [ANGLE_W-1:0] STEP     = 12'h07F,
    parameter int                 LOCK_CNT = 4
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               clear,
    input  logic               angle_valid,
    input  logic [ANGLE_W-1:0] angle_in,
    output logic [FREQ_W:0]    period,
    output logic [FREQ_W-1:0]  freq_est,
    output logic               est_valid,
    output logic               locked,
    output logic               step_err,
    output logic               range_err,
    output logic               timeout
);

    localparam int              PW       = FREQ_W + 1;
    localparam int              RW       = $clog2(LOCK_CNT + 1);
    localparam logic [PW-1:0]   TO_LIMIT = {{(PW-1){1'b1}}, 1'b0};
    localparam logic [PW:0]     PMAX     = (PW+1)'(CNT + 1);
    localparam logic [PW-1:0]   PMIN     = PW'(2);
    localparam logic [RW-1:0]   LOCK_MAX = RW'(LOCK_CNT);

    typedef enum logic [1:0] {IDLE, SYNC, MEASURE} state_t;

    state_t             state;
    logic [ANGLE_W-1:0] prev_angle;
    logic [PW-1:0]      ivl_cnt;
    logic [RW-1:0]      lock_run;

    logic               evt;
    logic               step_ok;
    logic               publish;
    logic [PW-1:0]      meas;
    logic [PW-1:0]      new_period;
    logic [FREQ_W-1:0]  new_freq;
    logic               new_range;
    logic [RW-1:0]      lock_next;

    assign evt     = angle_valid && (state != IDLE) && (angle_in != prev_angle);
    // Subtraction wraps modulo 2^ANGLE_W, so a step across zero is still a legal STEP.
    assign step_ok = (angle_in - prev_angle) == STEP;
    assign meas    = ivl_cnt + PW'(1);

`ifdef ANGLE_RATE_AVG_EN
    logic [PW-1:0]  hist [3];
    logic [1:0]     hist_n;
    logic [PW+1:0]  hist_sum;

    assign hist_sum   = {2'b00, hist[0]} + {2'b00, hist[1]} + {2'b00, hist[2]} + {2'b00, meas};
    assign new_period = hist_sum[PW+1:2];
    assign publish    = (hist_n == 2'd3);
`else
    assign new_period = meas;
    assign publish    = 1'b1;
`endif

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        new_freq  = '0;
        new_range = 1'b0;
        lock_next = RW'(1);
        if (new_period < PMIN) begin
            new_freq  = '1;
            new_range = 1'b1;
        end else if ({1'b0, new_period} > PMAX) begin
            new_range = 1'b1;
        end else begin
            new_freq = FREQ_W'(PMAX - {1'b0, new_period});
        end
        if (new_period == period)
            lock_next = (lock_run == LOCK_MAX) ? LOCK_MAX : lock_run + RW'(1);
    end

    always_ff @(posedge clock) begin
        // NOTE: non-blocking assignments only, so every register samples pre-edge values.
        if (reset || clear) begin
            state      <= IDLE;
            prev_angle <= '0;
            ivl_cnt    <= '0;
            lock_run   <= '0;
            period     <= '0;
            freq_est   <= '0;
            est_valid  <= 1'b0;
            locked     <= 1'b0;
            step_err   <= 1'b0;
            range_err  <= 1'b0;
            timeout    <= 1'b0;
`ifdef ANGLE_RATE_AVG_EN
            // NOTE: the history is reset too, keeping the average free of stale intervals.
            hist[0]    <= '0;
            hist[1]    <= '0;
            hist[2]    <= '0;
            hist_n     <= '0;
`endif
        end else begin
            est_valid <= 1'b0;
            timeout   <= 1'b0;
            if (angle_valid)
                prev_angle <= angle_in;

            case (state)
                IDLE: if (angle_valid) state <= SYNC;
                SYNC: begin
                    if (evt) begin
                        ivl_cnt <= '0;
                        state   <= MEASURE;
`ifdef ANGLE_RATE_AVG_EN
                        hist_n  <= '0;
`endif
                    end
                end
                MEASURE: begin
                    if (evt) begin
                        ivl_cnt <= '0;
`ifdef ANGLE_RATE_AVG_EN
                        hist[2] <= hist[1];
                        hist[1] <= hist[0];
                        hist[0] <= meas;
                        if (!publish)
                            hist_n <= hist_n + 2'd1;
`endif
                        if (publish) begin
                            period    <= new_period;
                            freq_est  <= new_freq;
                            est_valid <= 1'b1;
                            if (new_range)
                                range_err <= 1'b1;
                            if (step_ok) begin
                                lock_run <= lock_next;
                                locked   <= (lock_next == LOCK_MAX);
                            end
                        end
                    end else if (ivl_cnt == TO_LIMIT) begin
                        // Counter would reach all-ones: give up on this interval and resync.
                        timeout  <= 1'b1;
                        lock_run <= '0;
                        locked   <= 1'b0;
                        state    <= SYNC;
                    end else begin
                        ivl_cnt <= meas;
                    end
                end
                default: state <= IDLE;
            endcase

            if (evt && !step_ok) begin
                step_err <= 1'b1;
                lock_run <= '0;
                locked   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_angle_rate_meter.sv
// Bench for angle_rate_meter: a default instance plus a narrow one (FREQ_W=4, CNT=16) that can reach timeout quickly.
module tb_angle_rate_meter;

    logic        clock = 1'b0;
    logic        reset;
    logic        clear;
    logic        angle_valid;
    logic [11:0] angle_in;

    logic [16:0] big_period;
    logic [15:0] big_freq;
    logic        big_ev, big_lk, big_se, big_re, big_to;
    logic [4:0]  small_period;
    logic [3:0]  small_freq;
    logic        small_ev, small_lk, small_se, small_re, small_to;

    always #5 clock = ~clock;

    angle_rate_meter u_big (
        .clock(clock), .reset(reset), .clear(clear),
        .angle_valid(angle_valid), .angle_in(angle_in),
        .period(big_period), .freq_est(big_freq), .est_valid(big_ev),
        .locked(big_lk), .step_err(big_se), .range_err(big_re), .timeout(big_to)
    );

    angle_rate_meter #(.FREQ_W(4), .CNT(16)) u_small (
        .clock(clock), .reset(reset), .clear(clear),
        .angle_valid(angle_valid), .angle_in(angle_in),
        .period(small_period), .freq_est(small_freq), .est_valid(small_ev),
        .locked(small_lk), .step_err(small_se), .range_err(small_re), .timeout(small_to)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    bit started  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp)
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        else
            n_pass++;
    endtask

    // Behavioural model: intervals from edge timestamps, per instance.
    int          cnt_c  [2] = '{65536, 16};
    int          ones_c [2] = '{131071, 31};
    int          fmax_c [2] = '{65535, 15};
    int          m_st   [2];  // 0 idle, 1 sync, 2 measure
    logic [11:0] m_prev [2];
    int          m_last [2];
    int          m_period [2];
    int          m_freq [2];
    int          m_run  [2];
    bit          m_ev [2], m_lock [2], m_serr [2], m_rerr [2], m_to [2];

    task automatic model_edge(input int i);
        bit evt, ok;
        int p;
        if (reset || clear) begin
            m_st[i] = 0; m_prev[i] = '0; m_last[i] = 0; m_period[i] = 0; m_freq[i] = 0;
            m_run[i] = 0; m_ev[i] = 0; m_lock[i] = 0; m_serr[i] = 0; m_rerr[i] = 0; m_to[i] = 0;
            return;
        end
        m_ev[i] = 0;
        m_to[i] = 0;
        evt = angle_valid && (angle_in != m_prev[i]) && (m_st[i] != 0);
        ok  = 12'(angle_in - m_prev[i]) == 12'h07F;
        if (m_st[i] == 0) begin
            if (angle_valid) m_st[i] = 1;
        end else if (m_st[i] == 1) begin
            if (evt) begin m_st[i] = 2; m_last[i] = cyc; end
        end else if (evt) begin
            p = cyc - m_last[i];
            m_last[i] = cyc;
            m_ev[i] = 1;
            if (p < 2) begin m_freq[i] = fmax_c[i]; m_rerr[i] = 1; end
            else if (p > cnt_c[i] + 1) begin m_freq[i] = 0; m_rerr[i] = 1; end
            else m_freq[i] = cnt_c[i] + 1 - p;
            if (ok) begin
                m_run[i]  = (p == m_period[i]) ? ((m_run[i] < 4) ? m_run[i] + 1 : 4) : 1;
                m_lock[i] = (m_run[i] == 4);
            end
            m_period[i] = p;
        end else if (cyc - m_last[i] == ones_c[i]) begin
            m_to[i] = 1; m_run[i] = 0; m_lock[i] = 0; m_st[i] = 1;
        end
        if (evt && !ok) begin m_serr[i] = 1; m_run[i] = 0; m_lock[i] = 0; end
        if (angle_valid) m_prev[i] = angle_in;
    endtask

    initial begin
        forever begin
            @(posedge clock);
            cyc++;
            model_edge(0);
            model_edge(1);
            started = 1;
        end
    end

    task automatic cmp_inst(input int i, input string nm, input logic [16:0] per, input logic [15:0] frq,
                            input logic ev, input logic lk, input logic se, input logic re, input logic to);
        check({nm, ".period"},    64'(per), 64'(m_period[i]));
        check({nm, ".freq_est"},  64'(frq), 64'(m_freq[i]));
        check({nm, ".est_valid"}, 64'(ev),  64'(m_ev[i]));
        check({nm, ".locked"},    64'(lk),  64'(m_lock[i]));
        check({nm, ".step_err"},  64'(se),  64'(m_serr[i]));
        check({nm, ".range_err"}, 64'(re),  64'(m_rerr[i]));
        check({nm, ".timeout"},   64'(to),  64'(m_to[i]));
    endtask

    initial begin
        forever begin
            @(negedge clock);
            if (started) begin
                cmp_inst(0, "big", big_period, big_freq, big_ev, big_lk, big_se, big_re, big_to);
                cmp_inst(1, "small", 17'(small_period), 16'(small_freq),
                         small_ev, small_lk, small_se, small_re, small_to);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1);
    end

    // Stimulus: angle changes on a negedge become events on the following posedge.
    logic [11:0] ang;
    int          since;

    task automatic tick(input int n);
        repeat (n) begin @(negedge clock); since++; end
    endtask

    task automatic emit(input logic [11:0] a, input int gap);
        while (since < gap) begin @(negedge clock); since++; end
        angle_in = a;
        since    = 0;
    endtask

    task automatic step(input int gap);
        ang = ang + 12'h07F;
        emit(ang, gap);
    endtask

    task automatic chk_big(input string tag, input int per, input int frq, input bit ev, input bit lk);
        check({tag, ".big.period"},    64'(big_period), 64'(per));
        check({tag, ".big.freq_est"},  64'(big_freq),   64'(frq));
        check({tag, ".big.est_valid"}, 64'(big_ev),     64'(ev));
        check({tag, ".big.locked"},    64'(big_lk),     64'(lk));
    endtask

    task automatic restart(input logic [11:0] a);
        clear = 1'b1;
        tick(1);
        chk_big("clear", 0, 0, 1'b0, 1'b0);
        check("clear.big.step_err",  64'(big_se), 64'd0);
        check("clear.big.range_err", 64'(big_re), 64'd0);
        clear    = 1'b0;
        ang      = a;
        angle_in = a;
        since    = 0;
    endtask

    initial begin
        reset = 1'b1; clear = 1'b0; angle_valid = 1'b0; angle_in = '0; since = 0; ang = '0;
        tick(3);
        chk_big("reset", 0, 0, 1'b0, 1'b0);
        check("reset.big.timeout", 64'(big_to), 64'd0);
        reset = 1'b0;
        angle_valid = 1'b1;
        since = 0;

        // 1: steady 10-clock steps, lock after the 4th equal interval
        step(10);
        for (int k = 1; k <= 5; k++) begin
            step(10);
            tick(1);
            chk_big("t1", 10, 65527, 1'b1, k >= 4);
        end
        check("t1.big.step_err", 64'(big_se), 64'd0);
        check("t1.small.freq_est", 64'(small_freq), 64'd7);

        // 2: wrap-around across 0xFFF is a legal step
        restart(12'hF80);
        emit(12'hFFF, 20);
        emit(12'h07E, 20);
        tick(1);
        chk_big("t2a", 20, 65517, 1'b1, 1'b0);
        emit(12'h0FD, 20);
        tick(1);
        chk_big("t2b", 20, 65517, 1'b1, 1'b0);
        check("t2.big.step_err", 64'(big_se), 64'd0);

        // 3: one bad step of 0x080, then relock
        restart(12'h000);
        step(10);
        for (int k = 1; k <= 5; k++) step(10);
        ang = ang + 12'h080;
        emit(ang, 10);
        tick(1);
        chk_big("t3bad", 10, 65527, 1'b1, 1'b0);
        check("t3bad.big.step_err", 64'(big_se), 64'd1);
        for (int k = 1; k <= 4; k++) begin
            step(10);
            tick(1);
            chk_big("t3relock", 10, 65527, 1'b1, k == 4);
        end
        check("t3.big.step_err_sticky", 64'(big_se), 64'd1);

        // 4: rate change 10 -> 25
        restart(12'h000);
        step(10);
        for (int k = 1; k <= 4; k++) step(10);
        tick(1);
        check("t4pre.big.locked", 64'(big_lk), 64'd1);
        for (int k = 1; k <= 4; k++) begin
            step(25);
            tick(1);
            chk_big("t4", 25, 65512, 1'b1, k == 4);
        end

        // 5: hold angle; narrow instance times out 31 clocks after the last event
        tick(31);
        check("t5.small.timeout", 64'(small_to), 64'd1);
        check("t5.small.locked",  64'(small_lk), 64'd0);
        check("t5.big.timeout",   64'(big_to),   64'd0);
        tick(1);
        check("t5.small.timeout_pulse", 64'(small_to), 64'd0);
        step(40);
        tick(1);
        chk_big("t5hold", 40, 65497, 1'b1, 1'b0);
        check("t5.small.resync_no_est", 64'(small_ev), 64'd0);
        step(12);
        tick(1);
        chk_big("t5next", 12, 65525, 1'b1, 1'b0);
        check("t5.small.period",   64'(small_period), 64'd12);
        check("t5.small.freq_est", 64'(small_freq),   64'd5);

        // Range boundaries: 17/18 on the narrow instance, 2/1 on the default one
        restart(12'h000);
        step(10);
        step(17);
        tick(1);
        check("rng17.small.freq_est",  64'(small_freq), 64'd0);
        check("rng17.small.range_err", 64'(small_re),   64'd0);
        check("rng17.big.freq_est",    64'(big_freq),   64'd65520);
        step(2);
        tick(1);
        chk_big("rng2", 2, 65535, 1'b1, 1'b0);
        check("rng2.big.range_err",   64'(big_re),     64'd0);
        check("rng2.small.freq_est",  64'(small_freq), 64'd15);
        step(18);
        tick(1);
        check("rng18.small.range_err", 64'(small_re),   64'd1);
        check("rng18.small.freq_est",  64'(small_freq), 64'd0);
        step(1);
        tick(1);
        check("rng1.big.period",    64'(big_period), 64'd1);
        check("rng1.big.freq_est",  64'(big_freq),   64'd65535);
        check("rng1.big.range_err", 64'(big_re),     64'd1);

        // 6: reset mid-interval, first event after resync is silent
        restart(12'h000);
        step(10);
        step(10);
        step(10);
        tick(4);
        reset = 1'b1;
        tick(1);
        chk_big("t6rst", 0, 0, 1'b0, 1'b0);
        check("t6rst.big.step_err",  64'(big_se), 64'd0);
        check("t6rst.big.range_err", 64'(big_re), 64'd0);
        reset = 1'b0;
        since = 0;
        step(10);
        tick(1);
        check("t6.big.no_est_after_resync", 64'(big_ev), 64'd0);
        step(10);
        tick(1);
        chk_big("t6first", 10, 65527, 1'b1, 1'b0);

        tick(2);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/angle_rate_meter.md
Name: angle_rate_meter

Overview:
- Receive-side counterpart of the CORDIC angle generator. It observes the angle word stream fed to the CORDIC core and measures the clock interval between angle steps.
- From that interval it recovers the frequency word the generator was programmed with, and it checks step size, lock and timeout.
- It sits beside the CORDIC input for self-check and loopback monitoring, and reports to the control and status logic.

Parameters:
- ANGLE_W, 12, angle word width.
- FREQ_W, 16, recovered frequency width. The interval counter is FREQ_W+1 bits.
- CNT, 65536, generator terminal constant. Relation: period = CNT + 1 - freq.
- STEP, 12'h07F, expected angle increment per step, modulo 2^ANGLE_W.
- LOCK_CNT, 4, number of consecutive identical good periods required to assert lock.

Ports:
- clock  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high; overrides every other input.
- clear  in  1  synchronous soft clear: returns to IDLE and clears sticky flags.
- angle_valid  in  1  angle_in is sampled on cycles where this is high.
- angle_in  in  ANGLE_W  angle word under observation.
- period  out  FREQ_W+1  last measured interval in clocks.
- freq_est  out  FREQ_W  recovered frequency word.
- est_valid  out  1  one-cycle pulse; period and freq_est updated this cycle.
- locked  out  1  stable-rate indication.
- step_err  out  1  sticky: an angle delta differed from STEP.
- range_err  out  1  sticky: a period fell outside 2..CNT+1.
- timeout  out  1  one-cycle pulse: no angle step within 2^(FREQ_W+1)-1 clocks.

Behaviour:
- Reset or clear:
  - all outputs go to 0; state goes to IDLE; prev_angle, ivl_cnt and lock_run go to 0.
  - clear only acts when reset is low.
- Change event:
  - an event is angle_valid=1 and angle_in != prev_angle, in SYNC or MEASURE.
  - prev_angle updates on every valid sample.
- State IDLE:
  - on the first valid sample, latch prev_angle and go to SYNC. No event is possible in IDLE.
- State SYNC:
  - on an event, ivl_cnt<=0 and go to MEASURE.
  - the first partial interval is discarded; no est_valid is produced.
- State MEASURE:
  - ivl_cnt increments every cycle that has no event.
  - on an event: period<=ivl_cnt+1, ivl_cnt<=0, est_valid=1 on the next cycle. Latency is 1 clock from the event sample edge.
- freq_est:
  - registered together with period.
  - for period in 2..CNT+1: freq_est = CNT+1-period.
  - for period=1 or period>CNT+1: freq_est saturates to all-ones or zero respectively, and range_err is set.
- Step check on each event:
  - delta = (angle_in - prev_angle) mod 2^ANGLE_W, so wrap-around is legal (0xFFF -> 0x07E is a delta of 0x07F).
  - if delta != STEP: step_err sets, lock_run<=0, locked<=0. est_valid still pulses.
- Lock:
  - on a good event whose period equals the previous period, lock_run increments, saturating at LOCK_CNT.
  - on a good event with a different period, lock_run<=1.
  - locked = (lock_run == LOCK_CNT).
- Timeout:
  - ivl_cnt reaching all-ones in MEASURE pulses timeout for one cycle, clears lock, returns to SYNC and holds ivl_cnt.
- Simultaneous event and timeout: the event wins and no timeout pulse is produced.
- Sticky flags clear only on reset or clear.

Optional Feature:
- Macro: ANGLE_RATE_AVG_EN.
- Defined:
  - the last 4 intervals are kept in a shift register.
  - period = floor(sum/4); freq_est is derived from the averaged period.
  - est_valid is suppressed until 4 intervals have been captured since entering MEASURE, then pulses on every event.
  - lock compares successive averaged periods.
- Undefined: single-interval measurement as described above; no history registers.

Test Plan:
1. Angle steps by 0x07F every 10 clocks -> period=10, freq_est=65527, est_valid every 10 clocks, locked=1 after 4 identical good intervals, step_err=0.
2. Angle sequence 0xF80, 0xFFF, 0x07E, 0x0FD at a 20-clock spacing -> no step_err across the wrap; period=20, freq_est=65517.
3. One step of 0x080 inside a 10-clock stream -> step_err=1 and stays set; locked drops, then re-asserts after 4 further good equal intervals; clear=1 returns step_err to 0 and state to IDLE.
4. Rate changes from 10 to 25 clocks -> the first 25-clock event gives period=25, freq_est=65512, locked=0; locked=1 after the 4th identical interval.
5. Angle held constant for 131071 clocks in MEASURE -> a single timeout pulse, locked=0, no est_valid; the next two steps 12 clocks apart give period=12.
6. reset asserted mid-interval -> all outputs 0 the following cycle; the first event after re-sync produces no est_valid.
